// File: rtl/prio_encoder_stream.sv
// Streaming priority encoder. It captures an N-bit request vector, then emits
// the index of every set bit, one per accepted beat, in priority order.
// An all-zero vector produces a single beat flagged with out_zero.
module prio_encoder_stream #(
    parameter  int N         = 8,
    parameter  bit MSB_FIRST = 1'b1,
    localparam int W         = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         out_zero
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t         state_q, state_d;
    logic [N-1:0]   pending_q, pending_d;
    logic [W-1:0]   idx_c;
    logic [N-1:0]   clear_mask;
    logic           single_bit;
    logic           is_zero;

    // Pick the highest-priority set bit of the pending vector. The scan runs
    // toward the priority end so the last hit wins; zero pending gives index 0.
    always_comb begin
        idx_c = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < N; i++) begin
                if (pending_q[i]) idx_c = W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (pending_q[i]) idx_c = W'(i);
            end
        end
    end

    // One-hot mask of the bit being emitted, used to retire it on transfer.
    for (genvar gi = 0; gi < N; gi++) begin : gen_clear
        assign clear_mask[gi] = (idx_c == W'(gi));
    end

    assign is_zero    = (pending_q == '0);
    assign single_bit = ((pending_q & (pending_q - ONE)) == '0);

    // Outputs depend only on registered state and pending bits.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == EMIT);
        out_idx   = idx_c;
        out_last  = (state_q == EMIT) && single_bit;
        out_zero  = (state_q == EMIT) && is_zero;
    end

    // Next-state: capture in IDLE, retire one bit per accepted beat in EMIT.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        if (state_q == IDLE) begin
            if (in_valid) begin
                pending_d = in_vec;
                state_d   = EMIT;
            end
        end else begin
            if (out_ready) begin
                pending_d = pending_q & ~clear_mask;
                if (out_last) state_d = IDLE;
            end
        end
    end

    // State and pending registers; reset abandons any beat in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

endmodule
